// File: rtl/rs_conv_engine.sv
// Row-stationary 2-D convolution engine: DO_W MAC lanes, one output row per pass.
// Optional fused ReLU on the saturated lane outputs when CONV_RELU_EN is defined.

module rs_conv_lane #(
  parameter int INWIDTH = 16,
  parameter int IN_FRAC = 12,
  parameter int ACCW    = 36
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mac,
  input  logic                      first,
  input  logic signed [INWIDTH-1:0] w,
  input  logic signed [INWIDTH-1:0] x,
  output logic        [INWIDTH-1:0] y
);
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-INWIDTH+1){1'b0}}, {(INWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-INWIDTH+1){1'b1}}, {(INWIDTH-1){1'b0}}};

  logic signed [2*INWIDTH-1:0] prod;
  logic signed [ACCW-1:0]      acc, sh;

  assign prod = w * x;
  assign sh   = acc >>> IN_FRAC;

  // first MAC of a row overwrites instead of accumulating, which clears acc on COMP entry
  always_ff @(posedge clk) begin
    if (rst)      acc <= '0;
    else if (mac) acc <= (first ? '0 : acc) + ACCW'(prod);
  end

  always_comb begin
    if (sh > MAXV)      y = {1'b0, {(INWIDTH-1){1'b1}}};
    else if (sh < MINV) y = {1'b1, {(INWIDTH-1){1'b0}}};
    else                y = sh[INWIDTH-1:0];
`ifdef CONV_RELU_EN
    if (y[INWIDTH-1]) y = '0;
`else
`endif
  end
endmodule

module rs_conv_engine #(
  parameter int INWIDTH = 16,
  parameter int IN_FRAC = 12,
  parameter int DI_W    = 7,
  parameter int DI_H    = 7,
  parameter int FIL_S   = 3,
  localparam int DO_W   = DI_W - FIL_S + 1,
  localparam int DO_H   = DI_H - FIL_S + 1,
  localparam int RW     = $clog2(DO_H) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    fil_keep,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INWIDTH-1:0]      in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DO_W*INWIDTH-1:0] out_data,
  output logic [RW-1:0]           out_row,
  output logic                    busy,
  output logic                    done
);
  localparam int FS2   = FIL_S * FIL_S;
  localparam int IMG_N = DI_H * DI_W;
  localparam int TOTAL = FS2 + IMG_N;
  localparam int ACCW  = 2 * INWIDTH + $clog2(FS2);
  localparam int FW    = $clog2(FS2 + 1);
  localparam int IW    = $clog2(IMG_N + 1);
  localparam int LW    = $clog2(TOTAL + 1);
  localparam int KW    = $clog2(FIL_S + 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMP, OUT} state_t;
  state_t state, state_n;

  logic [LW-1:0]      ld_cnt;
  logic               fil_vld;
  logic [RW-1:0]      r;
  logic [KW-1:0]      k, c;
  logic [INWIDTH-1:0] filt [2**FW];
  logic [INWIDTH-1:0] img  [2**IW];
  logic               ld_last, comp_last, row_last;
  logic [FW-1:0]      fidx;
  logic [IW-1:0]      base;
  logic [DO_W-1:0][INWIDTH-1:0] y;

  assign ld_last   = ld_cnt == LW'(TOTAL - 1);
  assign comp_last = (k == KW'(FIL_S - 1)) && (c == KW'(FIL_S - 1));
  assign row_last  = r == RW'(DO_H - 1);
  assign in_ready  = state == LOAD;
  assign out_valid = state == OUT;
  assign busy      = state != IDLE;
  assign out_row   = r;
  assign out_data  = y;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (en) state_n = LOAD;
      LOAD: if (in_valid && ld_last) state_n = COMP;
      COMP: if (comp_last) state_n = OUT;
      OUT:  if (out_ready) state_n = row_last ? IDLE : COMP;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt  <= '0;
      fil_vld <= 1'b0;
      r       <= '0;
      k       <= '0;
      c       <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (en) begin
          // a kept filter is only trusted once a full load has completed
          ld_cnt <= (fil_keep && fil_vld) ? LW'(FS2) : '0;
          r      <= '0;
          k      <= '0;
          c      <= '0;
        end
        LOAD: if (in_valid) begin
          ld_cnt <= ld_cnt + 1'b1;
          if (ld_last) fil_vld <= 1'b1;
        end
        COMP: begin
          if (c == KW'(FIL_S - 1)) begin
            c <= '0;
            k <= comp_last ? '0 : k + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        OUT: if (out_ready) begin
          if (row_last) done <= 1'b1;
          else          r    <= r + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      if (ld_cnt < LW'(FS2)) filt[FW'(ld_cnt)] <= in_data;
      else                   img[IW'(ld_cnt - LW'(FS2))] <= in_data;
    end
  end

  assign fidx = FW'(k) * FW'(FIL_S) + FW'(c);
  assign base = (IW'(r) + IW'(k)) * IW'(DI_W) + IW'(c);

  for (genvar j = 0; j < DO_W; j++) begin : g_lane
    rs_conv_lane #(.INWIDTH(INWIDTH), .IN_FRAC(IN_FRAC), .ACCW(ACCW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .mac   (state == COMP),
      .first (k == '0 && c == '0),
      .w     (filt[fidx]),
      .x     (img[base + IW'(j)]),
      .y     (y[j])
    );
  end
endmodule

// File: tb/tb_rs_conv_engine.sv
// Randomized bench for rs_conv_engine with a direct-sum convolution reference model.
module tb_rs_conv_engine;
  localparam int W = 16, DI = 7, FS = 3, DOW = 5, DOH = 5, FS2 = 9;

  logic clk = 0, rst = 1, en = 0, fil_keep = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy, done;
  logic [W-1:0] in_data = '0;
  logic [DOW*W-1:0] out_data;
  logic [2:0] out_row;

  rs_conv_engine dut (
    .clk(clk), .rst(rst), .en(en), .fil_keep(fil_keep), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic signed [W-1:0] nf [FS2], ni [DI*DI], mf [FS2], mi [DI*DI];
  bit mfv = 0;
  logic [DOW*W-1:0] last_data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mlane(int r, int j);
    longint s = 0;
    for (int kk = 0; kk < FS; kk++)
      for (int cc = 0; cc < FS; cc++)
        s += longint'(mf[kk*FS+cc]) * longint'(mi[(r+kk)*DI + j + cc]);
    s = s >>> 12;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[W-1:0];
  endfunction

  function automatic logic [DOW*W-1:0] mrow(int r);
    logic [DOW*W-1:0] v = '0;
    for (int j = 0; j < DOW; j++) v[j*W +: W] = mlane(r, j);
    return v;
  endfunction

  function automatic logic signed [W-1:0] rnd();
    int v = int'($urandom_range(0, 16383)) - 8192;
    return W'(v);
  endfunction

  task automatic run(input bit keep, input bit noise, input bit stall2, input int abort_at);
    logic [W-1:0] words [$];
    logic [DOW*W-1:0] hold = '0;
    int n, idx = 0, extra = 0, rows = 0, ev, stall = 0;
    bit seen = 0, exp_done = 0, finished = 0;
    n = (keep && mfv) ? DI*DI : FS2 + DI*DI;
    if (n == FS2 + DI*DI) foreach (nf[i]) words.push_back(nf[i]);
    foreach (ni[i]) words.push_back(ni[i]);
    @(negedge clk); en = 1; fil_keep = keep; in_valid = 0; out_ready = 0;
    @(negedge clk); en = 0; cyc++;
    chk("busy_load", busy, 1);
    ev = cyc;
    for (int t = 0; t < 4000; t++) begin
      if (abort_at >= 0 && rows == abort_at) begin
        rst = 1; in_valid = 0; out_ready = 0; en = 0;
        @(negedge clk); rst = 0;
        chk("rst_in_ready", in_ready, 0); chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0); chk("rst_out_row", out_row, 0);
        mfv = 0;
        return;
      end
      if (exp_done) begin
        chk("done_pulse", done, 1); chk("idle_after", busy, 0);
        finished = 1;
        break;
      end else if (done) chk("done_early", done, 0);
      if (out_valid && !seen) begin chk("row_latency", cyc - ev, FS2 + 1); seen = 1; end
      if (idx < n) begin
        in_valid = $urandom_range(0, 3) != 0; in_data = words[idx];
      end else begin
        in_valid = noise ? 1'($urandom) : 1'b0; in_data = W'($urandom);
      end
      if (in_valid && in_ready) begin
        if (idx < n) begin
          idx++;
          if (idx == n) begin
            ev = cyc;
            if (n == FS2 + DI*DI) mf = nf;
            mi = ni; mfv = 1;
          end
        end else extra++;
      end
      if (stall2 && out_valid && out_row == 2 && stall < 10) begin
        out_ready = 0;
        if (stall == 0) hold = out_data;
        else chk("stall_stable", out_data, hold);
        stall++;
      end else out_ready = noise ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        chk("row_data", out_data, mrow(rows));
        chk("row_idx", out_row, rows);
        last_data = out_data; rows++; ev = cyc; seen = 0;
        if (rows == DOH) exp_done = 1;
      end
      en = (noise && !exp_done) ? 1'($urandom) : 1'b0;
      fil_keep = 1'($urandom);
      @(negedge clk); cyc++;
    end
    in_valid = 0; en = 0; out_ready = 0;
    if (!finished) chk("timeout", 0, 1);
    chk("words", idx, n);
    chk("extra_words", extra, 0);
    if (stall2) chk("stall_len", stall, 10);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_in_ready", in_ready, 0); chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0); chk("reset_done", done, 0);
    chk("reset_out_data", out_data, 0); chk("reset_out_row", out_row, 0);

    foreach (nf[i]) nf[i] = (i == 4) ? 16'sh1000 : 16'sh0;
    foreach (ni[i]) ni[i] = W'(i);
    run(0, 0, 0, -1);
    chk("ident_row4", last_data, {16'd40, 16'd39, 16'd38, 16'd37, 16'd36});

    foreach (nf[i]) nf[i] = 16'sh1000;
    foreach (ni[i]) ni[i] = 16'sh7000;
    run(0, 0, 0, -1);
    chk("sat_pos", last_data, {5{16'h7FFF}});
    foreach (ni[i]) ni[i] = 16'sh9000;
    run(1, 0, 0, -1);
`ifdef CONV_RELU_EN
    chk("sat_neg", last_data, {5{16'h0000}});
`else
    chk("sat_neg", last_data, {5{16'h8000}});
`endif

    in_valid = 1; in_data = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0); chk("idle_busy", busy, 0);
    end
    in_valid = 0;
    foreach (nf[i]) nf[i] = rnd();
    foreach (ni[i]) ni[i] = rnd();
    run(0, 1, 1, -1);
    run(1, 1, 0, -1);

    foreach (nf[i]) nf[i] = rnd();
    foreach (ni[i]) ni[i] = rnd();
    run(0, 0, 0, 1);
    run(1, 0, 0, -1);

    repeat (3) begin
      foreach (nf[i]) nf[i] = rnd();
      foreach (ni[i]) ni[i] = rnd();
      run(1'($urandom), 1, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
